// File: rtl/fc_wgt_feeder_if.sv
// Weight-stream and weight-memory signals of one FC weight feeder.
// master = feeder side, slave = FC engine plus weight memory.
interface fc_wgt_feeder_if #(
  parameter int DW = 104,
  parameter int AW = 20
);
  logic          wgt_read;
  logic [DW-1:0] wgt_out;
  logic          wgt_ready;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  wgt_read,
    input  mem_rdata,
    output wgt_out,
    output wgt_ready,
    output mem_rd_en,
    output mem_addr
  );

  modport slave (
    output wgt_read,
    output mem_rdata,
    input  wgt_out,
    input  wgt_ready,
    input  mem_rd_en,
    input  mem_addr
  );
endinterface

// File: rtl/fc_wgt_feeder.sv
// FC weight source: prefetches tile words from a 1-cycle-latency memory into a small FIFO.
// Optional macro FC_WGT_UNDERFLOW_CNT_EN adds a saturating 16-bit underflow event counter.
module fc_wgt_feeder #(
  parameter int WEIGHT_WIDTH = 13,
  parameter int TILING       = 8,
  parameter int IN_FEATURE   = 2304,
  parameter int OUT_FEATURE  = 2048,
  parameter int MEM_AW       = 20,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic clk1,
  input  logic rst_n,
  input  logic start,
  output logic underflow,
  output logic done,
  output logic busy,
`ifdef FC_WGT_UNDERFLOW_CNT_EN
  output logic [15:0] underflow_cnt,
`endif
  fc_wgt_feeder_if.master bus
);

  localparam int DW = TILING * WEIGHT_WIDTH;
  localparam int NT = IN_FEATURE * OUT_FEATURE / TILING;
  localparam int CW = $clog2(NT + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t          state;
  logic [DW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [OW-1:0]   fifo_count;
  logic            inflight;
  logic [MEM_AW-1:0] addr_cnt;
  logic [CW-1:0]   issued;
  logic [CW-1:0]   popped;

  logic            ready;
  logic            pop;
  logic            uf_event;
  logic            rd_en;
  logic            accept;
  logic [OW:0]     level;

  // Level after this edge; a new read is only issued if its data is sure to find room.
  always_comb begin
    ready    = (fifo_count != '0);
    pop      = bus.wgt_read && ready;
    uf_event = bus.wgt_read && !ready;
    level    = {1'b0, fifo_count} + {{OW{1'b0}}, inflight} - {{OW{1'b0}}, pop};
    rd_en    = (state == FETCH) && (level < (OW + 1)'(FIFO_DEPTH));
    done     = (state == DRAIN) && pop && (popped == CW'(NT - 1));
    accept   = start && ((state == IDLE) || done);
  end

  assign bus.wgt_ready = ready;
  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = addr_cnt;
  assign bus.wgt_out   = pop ? fifo_mem[rd_ptr] : '0;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk1) begin
    if (inflight) begin
      fifo_mem[wr_ptr] <= bus.mem_rdata;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= 1'b0;
      addr_cnt   <= '0;
      issued     <= '0;
      popped     <= '0;
      underflow  <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (inflight) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        popped <= popped + 1'b1;
      end
      case ({inflight, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (rd_en) begin
        addr_cnt <= addr_cnt + 1'b1;
        issued   <= issued + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
          end
        end
        FETCH: begin
          if (rd_en && (issued == CW'(NT - 1))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (done) begin
            state <= start ? FETCH : IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A new pass always starts from tile 0 with a clean underflow record.
      if (accept) begin
        addr_cnt  <= '0;
        issued    <= '0;
        popped    <= '0;
        underflow <= 1'b0;
      end
      if (uf_event) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef FC_WGT_UNDERFLOW_CNT_EN
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      underflow_cnt <= '0;
    end else if (uf_event) begin
      if (accept) begin
        underflow_cnt <= 16'd1;
      end else if (underflow_cnt != 16'hFFFF) begin
        underflow_cnt <= underflow_cnt + 1'b1;
      end
    end else if (accept) begin
      underflow_cnt <= '0;
    end
  end
`endif

endmodule
